mem_stage_ctrl: RTL and testbench

- Memory-stage controller sitting directly downstream of the EX/MEM pipeline register.
- Consumes its MemRead/MemWrite/CreateDump/address/store-data outputs and drives a multi-cycle data memory (cache) with a request/done handshake.
- Produces load data for the MEM/WB register, and a pipeline stall that freezes EX/MEM and all upstream registers while an access is outstanding.
- Flags illegal accesses and sequences the halt memory dump.

---
 rtl/mem_stage_defs.sv | 17 +
 rtl/mem_wait_timer.sv | 30 +++
 rtl/nBitRegister.sv | 17 +
 rtl/mem_stage_ctrl.sv | 126 ++++++++++++
 tb/tb_mem_stage_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_defs.sv
// mem_stage_defs: shared state encodings, default widths and pipeline NOP for the memory stage
package mem_stage_defs;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DUMP = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 16;

    // Instruction word the pipeline registers insert as a bubble.
    localparam logic [15:0] NOP_INSTR = 16'h0800;

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: saturating wait counter that flags when a memory wait has lasted TIMEOUT cycles
module mem_wait_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt_d, cnt_q;

    // Count waiting cycles, clear when idle, never wrap past TIMEOUT.
    always_comb begin
        cnt_d = clr ? '0 : (en && cnt_q != W'(TIMEOUT)) ? cnt_q + W'(1) : cnt_q;
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    // The current waiting cycle is the TIMEOUT-th one.
    assign expired = en && (cnt_q >= W'(TIMEOUT - 1));

endmodule

// File: rtl/nBitRegister.sv
// nBitRegister: N-bit register with asynchronous active-low clear
module nBitRegister #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    // Capture d every cycle; clear immediately while rst is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q <= '0;
        else      q <= d;
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage controller driving a multi-cycle data memory, stalling the pipeline and sequencing the halt dump.
// Optional build macro MEM_TIMEOUT_EN adds a wait timer and a sticky ERR state.
module mem_stage_ctrl
    import mem_stage_defs::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              create_dump_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    output logic              dump_req,
    input  logic              dump_done,
    output logic [DATA_W-1:0] rdata_out,
    output logic              stall_out,
    output logic              err
);

    logic [1:0]        state_d, state_q;
    logic [DATA_W-1:0] rdata_d, rdata_q;
    logic [0:0]        pend_d, pend_q;
    logic              acc, illegal, rd_op, capture, expired;
    logic              en_c, stall_c, err_c, dump_c;

    assign acc     = mem_read_in ^ mem_write_in;
    assign illegal = (mem_read_in & mem_write_in) | (acc & addr_in[0]);
    assign rd_op   = mem_read_in & ~mem_write_in;

`ifdef MEM_TIMEOUT_EN
    logic timing;
    assign timing = (state_q == BUSY) || (state_q == DUMP);
    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (~timing),
        .en      (timing),
        .expired (expired)
    );
`else
    assign expired = 1'b0;
`endif

    // Next-state and request decode; a halt arriving with an access is remembered in pend and taken once the access completes.
    always_comb begin
        state_d = state_q;
        pend_d  = 1'b0;
        en_c    = 1'b0;
        stall_c = 1'b0;
        err_c   = 1'b0;
        dump_c  = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend_q[0]) begin
                    dump_c  = 1'b1;
                    stall_c = 1'b1;
                    state_d = DUMP;
                end else if (illegal) begin
                    err_c = 1'b1;
                end else if (acc) begin
                    en_c = 1'b1;
                    if (mem_done) begin
                        capture = rd_op;
                        pend_d  = create_dump_in;
                    end else begin
                        stall_c = 1'b1;
                        state_d = BUSY;
                    end
                end else if (create_dump_in) begin
                    dump_c  = 1'b1;
                    stall_c = 1'b1;
                    state_d = DUMP;
                end
            end
            BUSY: begin
                if (mem_done) begin
                    capture = rd_op;
                    pend_d  = create_dump_in;
                    state_d = IDLE;
                end else begin
                    stall_c = 1'b1;
                    state_d = expired ? ERR : BUSY;
                end
            end
            DUMP: begin
                if (dump_done) begin
                    state_d = IDLE;
                end else begin
                    stall_c = 1'b1;
                    state_d = expired ? ERR : DUMP;
                end
            end
            default: begin
                stall_c = 1'b1;
                err_c   = 1'b1;
            end
        endcase
        rdata_d = capture ? mem_rdata : rdata_q;
    end

    nBitRegister #(.N(2))      u_state (.clk(clk), .rst(rst), .d(state_d), .q(state_q));
    nBitRegister #(.N(DATA_W)) u_rdata (.clk(clk), .rst(rst), .d(rdata_d), .q(rdata_q));
    nBitRegister #(.N(1))      u_pend  (.clk(clk), .rst(rst), .d(pend_d),  .q(pend_q));

    // Every output is forced to zero while reset is held, including the pass-through paths.
    assign mem_en    = rst & en_c;
    assign mem_wr    = mem_en & mem_write_in;
    assign mem_addr  = rst ? addr_in : '0;
    assign mem_wdata = rst ? wdata_in : '0;
    assign dump_req  = rst & dump_c;
    assign stall_out = rst & stall_c;
    assign err       = rst & err_c;
    assign rdata_out = !rst ? '0 : capture ? mem_rdata : rdata_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: vector table, directed corner sequences and randomized model checking for mem_stage_ctrl
module tb_mem_stage_ctrl;

    localparam int TMO = 8;

    logic        clk = 1'b0, rst = 1'b0;
    logic        rd = 0, wr = 0, dmp = 0, done = 0, ddone = 0;
    logic [15:0] addr = 0, wdata = 0, mrdata = 0;
    logic        mem_en, mem_wr, dump_req, stall_out, err;
    logic [15:0] mem_addr, mem_wdata, rdata_out;

    int n_pass = 0, n_total = 0;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .mem_read_in(rd), .mem_write_in(wr), .create_dump_in(dmp),
        .addr_in(addr), .wdata_in(wdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mrdata), .mem_done(done),
        .dump_req(dump_req), .dump_done(ddone),
        .rdata_out(rdata_out), .stall_out(stall_out), .err(err)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic chk_all(input string t, input logic e_en, input logic e_wr, input logic e_st,
                           input logic e_er, input logic e_dq, input logic [15:0] e_rd);
        chk({t, ".mem_en"},    16'(mem_en),    16'(e_en));
        chk({t, ".mem_wr"},    16'(mem_wr),    16'(e_wr));
        chk({t, ".stall_out"}, 16'(stall_out), 16'(e_st));
        chk({t, ".err"},       16'(err),       16'(e_er));
        chk({t, ".dump_req"},  16'(dump_req),  16'(e_dq));
        chk({t, ".rdata_out"}, rdata_out,      e_rd);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic clr_in();
        rd = 0; wr = 0; dmp = 0; done = 0; ddone = 0;
        addr = 0; wdata = 0; mrdata = 0;
    endtask

    // Pulse reset between edges; called right after a step().
    task automatic do_reset();
        clr_in();
        rst = 0;
        #2;
        rst = 1;
    endtask

    // Reference model: what is outstanding, plus the last value loaded.
    logic        m_busy, m_dumping, m_pend, m_err;
    int          m_wait;
    logic [15:0] m_last;

    typedef struct {
        logic en, mwr, stall, er, dq;
        logic [15:0] rdo;
    } exp_t;

    task automatic model_reset();
        m_busy = 0; m_dumping = 0; m_pend = 0; m_err = 0; m_wait = 0; m_last = 0;
    endtask

    task automatic model_step(output exp_t e);
        logic p;
        e = '{en: 0, mwr: 0, stall: 0, er: 0, dq: 0, rdo: m_last};
        p = m_pend;
        m_pend = 0;
        if (m_err) begin
            e.er = 1;
            e.stall = 1;
        end else if (m_busy) begin
            if (done) begin
                if (rd && !wr) begin e.rdo = mrdata; m_last = mrdata; end
                m_busy = 0; m_wait = 0; m_pend = dmp;
            end else begin
                e.stall = 1;
                m_wait++;
`ifdef MEM_TIMEOUT_EN
                if (m_wait >= TMO) begin m_err = 1; m_busy = 0; end
`endif
            end
        end else if (m_dumping) begin
            if (ddone) begin
                m_dumping = 0; m_wait = 0;
            end else begin
                e.stall = 1;
                m_wait++;
`ifdef MEM_TIMEOUT_EN
                if (m_wait >= TMO) begin m_err = 1; m_dumping = 0; end
`endif
            end
        end else if (p) begin
            e.dq = 1; e.stall = 1; m_dumping = 1;
        end else if ((rd && wr) || ((rd || wr) && addr[0])) begin
            e.er = 1;
        end else if (rd || wr) begin
            e.en = 1; e.mwr = wr;
            if (done) begin
                if (rd) begin e.rdo = mrdata; m_last = mrdata; end
                m_pend = dmp;
            end else begin
                e.stall = 1; m_busy = 1;
            end
        end else if (dmp) begin
            e.dq = 1; e.stall = 1; m_dumping = 1;
        end
    endtask

    typedef struct {
        logic rd, wr, dmp;
        logic [15:0] addr, wdata;
        logic done;
        logic [15:0] mrd;
        logic en, mwr, stall, er, dq;
        logic [15:0] rdo;
    } vec_t;

    vec_t tv[9];

    initial begin
        exp_t e;
        tv[0] = '{1,0,0,16'h0010,16'h0000,1,16'hBEEF, 1,0,0,0,0,16'hBEEF};
        tv[1] = '{0,1,0,16'h0020,16'h1234,1,16'hDEAD, 1,1,0,0,0,16'h0000};
        tv[2] = '{1,0,0,16'h0030,16'h0000,0,16'h0000, 1,0,1,0,0,16'h0000};
        tv[3] = '{1,0,0,16'h0003,16'h0000,0,16'h0000, 0,0,0,1,0,16'h0000};
        tv[4] = '{1,1,0,16'h0010,16'h5555,0,16'h0000, 0,0,0,1,0,16'h0000};
        tv[5] = '{0,1,0,16'h0005,16'h4444,1,16'h1111, 0,0,0,1,0,16'h0000};
        tv[6] = '{0,0,1,16'h0000,16'h0000,0,16'h0000, 0,0,1,0,1,16'h0000};
        tv[7] = '{0,0,0,16'h0002,16'h0000,1,16'h7777, 0,0,0,0,0,16'h0000};
        tv[8] = '{1,0,1,16'h0008,16'h0000,0,16'h0000, 1,0,1,0,0,16'h0000};

        // Reset state with requests applied: everything must stay 0.
        rd = 1; addr = 16'h0010; dmp = 1; wdata = 16'h9999;
        #3;
        chk_all("reset", 0, 0, 0, 0, 0, 16'h0000);
        chk("reset.mem_addr", mem_addr, 16'h0000);
        chk("reset.mem_wdata", mem_wdata, 16'h0000);

        // Single-cycle responses from IDLE.
        for (int i = 0; i < 9; i++) begin
            step();
            do_reset();
            rd = tv[i].rd; wr = tv[i].wr; dmp = tv[i].dmp; addr = tv[i].addr;
            wdata = tv[i].wdata; done = tv[i].done; mrdata = tv[i].mrd;
            samp();
            chk_all($sformatf("vec%0d", i), tv[i].en, tv[i].mwr, tv[i].stall, tv[i].er, tv[i].dq, tv[i].rdo);
            chk($sformatf("vec%0d.mem_addr", i), mem_addr, tv[i].addr);
            chk($sformatf("vec%0d.mem_wdata", i), mem_wdata, tv[i].wdata);
        end

        // Load hit, then store miss that must leave the load data alone.
        step(); do_reset();
        rd = 1; addr = 16'h0010; done = 1; mrdata = 16'hBEEF;
        samp(); chk_all("hit", 1, 0, 0, 0, 0, 16'hBEEF);
        step(); clr_in();
        samp(); chk_all("hit_after", 0, 0, 0, 0, 0, 16'hBEEF);
        step(); wr = 1; addr = 16'h0020; wdata = 16'h1234;
        samp(); chk_all("st_req", 1, 1, 1, 0, 0, 16'hBEEF);
        chk("st_req.mem_addr", mem_addr, 16'h0020);
        chk("st_req.mem_wdata", mem_wdata, 16'h1234);
        for (int k = 0; k < 3; k++) begin
            step(); samp(); chk_all($sformatf("st_wait%0d", k), 0, 0, 1, 0, 0, 16'hBEEF);
        end
        step(); done = 1; mrdata = 16'hFFFF;
        samp(); chk_all("st_done", 0, 0, 0, 0, 0, 16'hBEEF);
        step(); clr_in();
        samp(); chk_all("st_after", 0, 0, 0, 0, 0, 16'hBEEF);

        // Halt alone: one dump_req pulse, stall until dump_done ten cycles later.
        step(); dmp = 1;
        samp(); chk_all("dump_req", 0, 0, 1, 0, 1, 16'hBEEF);
        for (int k = 0; k < 9; k++) begin
            step(); samp(); chk_all($sformatf("dump_wait%0d", k), 0, 0, 1, 0, 0, 16'hBEEF);
        end
        step(); ddone = 1; dmp = 0;
        samp(); chk_all("dump_done", 0, 0, 0, 0, 0, 16'hBEEF);
        step(); ddone = 0;
        samp(); chk_all("dump_idle", 0, 0, 0, 0, 0, 16'hBEEF);

        // Halt with a load: load completes first, dump_req the following cycle.
        step(); rd = 1; dmp = 1; addr = 16'h0040;
        samp(); chk_all("ld_dmp_req", 1, 0, 1, 0, 0, 16'hBEEF);
        step(); samp(); chk_all("ld_dmp_wait", 0, 0, 1, 0, 0, 16'hBEEF);
        step(); done = 1; mrdata = 16'h5A5A;
        samp(); chk_all("ld_dmp_done", 0, 0, 0, 0, 0, 16'h5A5A);
        step(); clr_in();
        samp(); chk_all("ld_dmp_dreq", 0, 0, 1, 0, 1, 16'h5A5A);
        step(); samp(); chk_all("ld_dmp_dwait", 0, 0, 1, 0, 0, 16'h5A5A);
        step(); ddone = 1;
        samp(); chk_all("ld_dmp_ddone", 0, 0, 0, 0, 0, 16'h5A5A);
        step(); ddone = 0;

        // Reset while BUSY: outputs drop at once, fresh load afterwards works.
        rd = 1; addr = 16'h0060; wdata = 16'hABCD;
        samp(); chk_all("rm_req", 1, 0, 1, 0, 0, 16'h5A5A);
        step(); samp(); chk_all("rm_busy", 0, 0, 1, 0, 0, 16'h5A5A);
        #1 rst = 0;
        #1 chk_all("rm_reset", 0, 0, 0, 0, 0, 16'h0000);
        chk("rm_reset.mem_addr", mem_addr, 16'h0000);
        chk("rm_reset.mem_wdata", mem_wdata, 16'h0000);
        step(); rst = 1;
        samp(); chk_all("rm_reissue", 1, 0, 1, 0, 0, 16'h0000);
        step(); done = 1; mrdata = 16'h0C0C;
        samp(); chk_all("rm_done", 0, 0, 0, 0, 0, 16'h0C0C);

`ifdef MEM_TIMEOUT_EN
        // Load that never completes: ERR after TMO busy cycles, sticky until reset.
        step(); do_reset();
        rd = 1; addr = 16'h0050;
        samp(); chk_all("to_req", 1, 0, 1, 0, 0, 16'h0000);
        for (int k = 0; k < TMO; k++) begin
            step(); samp(); chk_all($sformatf("to_wait%0d", k), 0, 0, 1, 0, 0, 16'h0000);
        end
        for (int k = 0; k < 3; k++) begin
            step(); samp(); chk_all($sformatf("to_err%0d", k), 0, 0, 1, 1, 0, 16'h0000);
        end
        step(); done = 1; mrdata = 16'h3333;
        samp(); chk_all("to_err_done", 0, 0, 1, 1, 0, 16'h0000);
        step(); do_reset();
        samp(); chk_all("to_cleared", 0, 0, 0, 0, 0, 16'h0000);
`endif

        // Randomized traffic against the reference model.
        step(); do_reset(); model_reset();
        for (int i = 0; i < 600; i++) begin
            step();
            if (i % 150 == 149) begin
                do_reset();
                model_reset();
            end
            rd     = ($urandom_range(0, 9) < 4);
            wr     = ($urandom_range(0, 9) < 3);
            dmp    = ($urandom_range(0, 9) == 0);
            addr   = 16'($urandom) & (($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'hFFFE);
            wdata  = 16'($urandom);
            mrdata = 16'($urandom);
            done   = ($urandom_range(0, 9) < 4);
            ddone  = ($urandom_range(0, 9) < 3);
            samp();
            model_step(e);
            chk_all($sformatf("rnd%0d", i), e.en, e.mwr, e.stall, e.er, e.dq, e.rdo);
            chk($sformatf("rnd%0d.mem_addr", i), mem_addr, addr);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
